// File: rtl/clkgen_pkg.sv
// clkgen_pkg: shared FSM states and channel limit for the multi-channel clock generator
package clkgen_pkg;
    typedef enum logic [1:0] {RUN, HOLD, SETTLE} state_t;
    localparam int MAX_NCH = 8;
endpackage

// File: rtl/clkgen_chan.sv
// clkgen_chan: one divided-clock channel with phase-loadable counter, duty decode and tick
module clkgen_chan #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             i_load,
    input  logic             i_gate,
    input  logic [DIV_W-1:0] i_div,
    input  logic [DIV_W-1:0] i_phase,
    output logic             o_clk,
    output logic             o_tick
);
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_ld;
    logic [DIV_W-1:0] w_nxt;
    logic [DIV_W-1:0] w_half;

    // next count: phase preload while held, otherwise wrap at div-1; high time rounds up
    always_comb begin
        w_ld   = (i_phase == '0) ? '0 : i_div - i_phase;
        w_nxt  = i_load ? w_ld : (r_cnt >= i_div - DIV_W'(1)) ? '0 : r_cnt + DIV_W'(1);
        w_half = DIV_W'(({1'b0, i_div} + (DIV_W+1)'(1)) >> 1);
    end

    // outputs are decoded from the next count so they come straight from flops
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_cnt  <= '0;
            o_clk  <= 1'b0;
            o_tick <= 1'b0;
        end else begin
            r_cnt  <= w_nxt;
            o_clk  <= i_gate & (w_nxt < w_half);
            o_tick <= i_gate & (w_nxt == '0);
        end
    end
endmodule

// File: rtl/clkgen_multi.sv
// clkgen_multi: NCH phase-coherent divided clocks with runtime div/phase reconfiguration
module clkgen_multi
    import clkgen_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [2:0]       cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] cfg_phase,
    output logic             cfg_err,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick,
    output logic             locked
);
    state_t           r_state;
    state_t           w_nxt;
    logic [DIV_W-1:0] r_div [NCH];
    logic [DIV_W-1:0] r_phase [NCH];
    logic [DIV_W-1:0] r_settle;
    logic [DIV_W-1:0] w_max;
    logic             r_err;
    logic             r_locked;
    logic             w_acc;
    logic             w_bad;
    logic             w_load;
    logic             w_gate;

    assign cfg_ready = (r_state == RUN);
    assign cfg_err   = r_err;
    assign locked    = r_locked;
    assign w_load    = (r_state == HOLD);
    assign w_gate    = (w_nxt != HOLD);

    // request acceptance, validity and the longest channel period
    always_comb begin
        w_acc = cfg_valid & cfg_ready;
        w_bad = (cfg_div < DIV_W'(2)) | (cfg_phase >= cfg_div) | ({1'b0, cfg_ch} >= 4'(NCH));
        w_max = '0;
        for (int k = 0; k < NCH; k++)
            w_max = (r_div[k] > w_max) ? r_div[k] : w_max;
    end

    // next state: a good request holds all channels, settle runs one full longest period
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            RUN:     w_nxt = (w_acc && !w_bad) ? HOLD : RUN;
            HOLD:    w_nxt = SETTLE;
            SETTLE:  w_nxt = (r_settle == DIV_W'(1)) ? RUN : SETTLE;
            default: w_nxt = HOLD;
        endcase
    end

    // state, settle countdown, per-channel configuration and status flags
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state  <= HOLD;
            r_settle <= '0;
            r_err    <= 1'b0;
            r_locked <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                r_div[k]   <= DIV_W'(DEF_DIV);
                r_phase[k] <= '0;
            end
        end else begin
            r_state  <= w_nxt;
            r_err    <= w_acc & w_bad;
            r_locked <= (r_state == RUN) & ~(w_acc & ~w_bad);
            r_settle <= (r_state == HOLD) ? w_max : (r_state == SETTLE) ? r_settle - DIV_W'(1) : r_settle;
            for (int k = 0; k < NCH; k++) begin
                if (w_acc && !w_bad && cfg_ch == 3'(k)) begin
                    r_div[k]   <= cfg_div;
                    r_phase[k] <= cfg_phase;
                end
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        clkgen_chan #(.DIV_W(DIV_W)) u_chan (
            .clk     (clk),
            .nrst    (nrst),
            .i_load  (w_load),
            .i_gate  (w_gate),
            .i_div   (r_div[g]),
            .i_phase (r_phase[g]),
            .o_clk   (clk_out[g]),
            .o_tick  (tick[g])
        );
    end
endmodule

// File: tb/tb_clkgen_multi.sv
// tb_clkgen_multi: directed scenario checks for the multi-channel clock generator
module tb_clkgen_multi;
    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [2:0] cfg_ch = '0;
    logic [7:0] cfg_div = '0;
    logic [7:0] cfg_phase = '0;
    logic       cfg_ready;
    logic       cfg_err;
    logic       locked;
    logic [1:0] clk_out;
    logic [1:0] tick;
    int checks = 0;
    int failures = 0;

    clkgen_multi #(.NCH(2), .DIV_W(8), .DEF_DIV(2)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task step;
        @(posedge clk);
        #1;
    endtask

    task do_cfg(input logic [2:0] ch, input logic [7:0] d, input logic [7:0] p);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = d;
        cfg_phase = p;
        step;
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset;
        nrst = 1'b0;
        cfg_valid = 1'b0;
        step;
        step;
        checks++;
        if ({clk_out, tick, locked, cfg_ready, cfg_err} !== 7'b0) begin
            failures++;
            $display("FAIL reset_state got=%b want=0000000", {clk_out, tick, locked, cfg_ready, cfg_err});
        end
        nrst = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            step;
            checks++;
            if (clk_out !== ((j % 2 == 1) ? 2'b11 : 2'b00)) begin
                failures++;
                $display("FAIL reset_clk j=%0d got=%b want=%b", j, clk_out, (j % 2 == 1) ? 2'b11 : 2'b00);
            end
            checks++;
            if (tick !== ((j % 2 == 1) ? 2'b11 : 2'b00)) begin
                failures++;
                $display("FAIL reset_tick j=%0d got=%b want=%b", j, tick, (j % 2 == 1) ? 2'b11 : 2'b00);
            end
            checks++;
            if (locked !== (j >= 4)) begin
                failures++;
                $display("FAIL reset_locked j=%0d got=%b want=%b", j, locked, j >= 4);
            end
            checks++;
            if (cfg_ready !== (j >= 3)) begin
                failures++;
                $display("FAIL reset_ready j=%0d got=%b want=%b", j, cfg_ready, j >= 3);
            end
        end
    endtask

    task automatic test_phase;
        logic [11:0] c0 = 12'b101010101010;
        logic [11:0] c1 = 12'b011001100110;
        logic [11:0] t1 = 12'b010001000100;
        do_cfg(3'd1, 8'd4, 8'd1);
        checks++;
        if ({clk_out, tick, locked, cfg_ready} !== 6'b0) begin
            failures++;
            $display("FAIL phase_hold got=%b want=000000", {clk_out, tick, locked, cfg_ready});
        end
        for (int j = 1; j <= 12; j++) begin
            step;
            checks++;
            if (clk_out !== {c1[12-j], c0[12-j]}) begin
                failures++;
                $display("FAIL phase_clk j=%0d got=%b want=%b", j, clk_out, {c1[12-j], c0[12-j]});
            end
            checks++;
            if (tick !== {t1[12-j], c0[12-j]}) begin
                failures++;
                $display("FAIL phase_tick j=%0d got=%b want=%b", j, tick, {t1[12-j], c0[12-j]});
            end
            checks++;
            if (locked !== (j >= 6)) begin
                failures++;
                $display("FAIL phase_locked j=%0d got=%b want=%b", j, locked, j >= 6);
            end
        end
    endtask

    task automatic test_div3;
        logic [11:0] c0 = 12'b110110110110;
        logic [11:0] t0 = 12'b100100100100;
        logic [11:0] c1 = 12'b011001100110;
        logic [11:0] t1 = 12'b010001000100;
        do_cfg(3'd0, 8'd3, 8'd0);
        checks++;
        if ({clk_out, tick, locked} !== 5'b0) begin
            failures++;
            $display("FAIL div3_hold got=%b want=00000", {clk_out, tick, locked});
        end
        for (int j = 1; j <= 12; j++) begin
            step;
            checks++;
            if (clk_out !== {c1[12-j], c0[12-j]}) begin
                failures++;
                $display("FAIL div3_clk j=%0d got=%b want=%b", j, clk_out, {c1[12-j], c0[12-j]});
            end
            checks++;
            if (tick !== {t1[12-j], t0[12-j]}) begin
                failures++;
                $display("FAIL div3_tick j=%0d got=%b want=%b", j, tick, {t1[12-j], t0[12-j]});
            end
            checks++;
            if (locked !== (j >= 6)) begin
                failures++;
                $display("FAIL div3_locked j=%0d got=%b want=%b", j, locked, j >= 6);
            end
        end
    endtask

    task automatic test_errors;
        logic [1:0] ec[4] = '{2'b01, 2'b11, 2'b10, 2'b01};
        logic [1:0] et[4] = '{2'b01, 2'b10, 2'b00, 2'b01};
        logic [2:0] rc[3] = '{3'd0, 3'd0, 3'd2};
        logic [7:0] rd[3] = '{8'd5, 8'd1, 8'd4};
        logic [7:0] rp[3] = '{8'd5, 8'd0, 8'd0};
        for (int i = 0; i < 4; i++) begin
            cfg_valid = (i < 3);
            if (i < 3) begin
                cfg_ch    = rc[i];
                cfg_div   = rd[i];
                cfg_phase = rp[i];
            end
            step;
            checks++;
            if (cfg_err !== (i < 3)) begin
                failures++;
                $display("FAIL err_pulse i=%0d got=%b want=%b", i, cfg_err, i < 3);
            end
            checks++;
            if ({locked, cfg_ready} !== 2'b11) begin
                failures++;
                $display("FAIL err_status i=%0d got=%b want=11", i, {locked, cfg_ready});
            end
            checks++;
            if (clk_out !== ec[i] || tick !== et[i]) begin
                failures++;
                $display("FAIL err_outputs i=%0d got=%b/%b want=%b/%b", i, clk_out, tick, ec[i], et[i]);
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [1:0] ec[4] = '{2'b11, 2'b01, 2'b10, 2'b01};
        logic [1:0] et[4] = '{2'b11, 2'b00, 2'b10, 2'b01};
        do_cfg(3'd1, 8'd2, 8'd0);
        cfg_valid = 1'b1;
        cfg_ch    = 3'd0;
        cfg_div   = 8'd2;
        cfg_phase = 8'd0;
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL hold_ready got=%b want=0", cfg_ready);
        end
        for (int i = 0; i < 4; i++) begin
            step;
            checks++;
            if (cfg_ready !== (i == 3) || locked !== 1'b0) begin
                failures++;
                $display("FAIL settle_ready i=%0d got=%b/%b want=%b/0", i, cfg_ready, locked, i == 3);
            end
            checks++;
            if (clk_out !== ec[i] || tick !== et[i]) begin
                failures++;
                $display("FAIL settle_outputs i=%0d got=%b/%b want=%b/%b", i, clk_out, tick, ec[i], et[i]);
            end
        end
        step;
        cfg_valid = 1'b0;
        checks++;
        if ({clk_out, tick, locked, cfg_ready} !== 6'b0) begin
            failures++;
            $display("FAIL accept_first_run got=%b want=000000", {clk_out, tick, locked, cfg_ready});
        end
        for (int j = 1; j <= 4; j++) begin
            step;
            checks++;
            if (clk_out !== ((j % 2 == 1) ? 2'b11 : 2'b00) || tick !== clk_out) begin
                failures++;
                $display("FAIL coherent j=%0d got=%b/%b want=%b", j, clk_out, tick, (j % 2 == 1) ? 2'b11 : 2'b00);
            end
            checks++;
            if (locked !== (j >= 4)) begin
                failures++;
                $display("FAIL coherent_locked j=%0d got=%b want=%b", j, locked, j >= 4);
            end
        end
    endtask

    task automatic test_reset_mid;
        do_cfg(3'd0, 8'd200, 8'd0);
        for (int i = 1; i <= 5; i++) begin
            step;
            checks++;
            if (clk_out[0] !== 1'b1 || cfg_ready !== 1'b0) begin
                failures++;
                $display("FAIL div200_settle i=%0d got=%b/%b want=1/0", i, clk_out[0], cfg_ready);
            end
        end
        nrst = 1'b0;
        step;
        checks++;
        if ({clk_out, tick, locked, cfg_ready, cfg_err} !== 7'b0) begin
            failures++;
            $display("FAIL midreset_state got=%b want=0000000", {clk_out, tick, locked, cfg_ready, cfg_err});
        end
        nrst = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            step;
            checks++;
            if (clk_out !== ((j % 2 == 1) ? 2'b11 : 2'b00)) begin
                failures++;
                $display("FAIL midreset_clk j=%0d got=%b want=%b", j, clk_out, (j % 2 == 1) ? 2'b11 : 2'b00);
            end
            checks++;
            if (locked !== (j >= 4)) begin
                failures++;
                $display("FAIL midreset_locked j=%0d got=%b want=%b", j, locked, j >= 4);
            end
        end
    endtask

    initial begin
        test_reset;
        test_phase;
        test_div3;
        test_errors;
        test_back_to_back;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
